// File: rtl/vigna_pkg.sv
// Shared vigna definitions: access sizes, LSU state codes, request record and
// the lane-mask / load-extension helpers used by the load/store unit.
package vigna_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_BEAT0 = 2'd1;
    localparam logic [1:0] ST_BEAT1 = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    typedef struct packed {
        logic        write;
        logic [1:0]  size;
        logic        sgn;
        logic [1:0]  off;
        logic [31:0] wdata;
    } lsu_req_t;

    // Size code 3 is treated as a word access.
    function automatic logic [3:0] size_mask(input logic [1:0] size);
        case (size)
            SZ_B:    return 4'b0001;
            SZ_H:    return 4'b0011;
            SZ_W:    return 4'b1111;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] load_extend(input logic [31:0] data, input logic [1:0] size,
                                                input logic sgn);
        case (size)
            SZ_B:    return {{24{sgn & data[7]}}, data[7:0]};
            SZ_H:    return {{16{sgn & data[15]}}, data[15:0]};
            SZ_W:    return data;
            default: return data;
        endcase
    endfunction

endpackage

// File: rtl/vigna_lsu_if.sv
// Word-aligned valid/ready data bus between the LSU (master) and memory (slave).
interface vigna_lsu_if;
    logic        d_valid;
    logic        d_ready;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_wstrb;
    logic [31:0] d_rdata;

    modport master (output d_valid, d_addr, d_wdata, d_wstrb, input d_ready, d_rdata);
    modport slave  (input d_valid, d_addr, d_wdata, d_wstrb, output d_ready, d_rdata);
endinterface

// File: rtl/vigna_lsu_align.sv
// Byte-lane alignment: store strobes/data shifted into an 8-lane (two word) window,
// and the matching read-side shift plus sign/zero extension.
module vigna_lsu_align import vigna_pkg::*; (
    input  logic [1:0]  off_i,
    input  logic [1:0]  size_i,
    input  logic        sgn_i,
    input  logic [31:0] wdata_i,
    input  logic [63:0] rdata_i,
    output logic [7:0]  smask_o,
    output logic [63:0] swdata_o,
    output logic        misalign_o,
    output logic [31:0] ldata_o
);
    logic [4:0] sh;

    assign sh         = {off_i, 3'b000};
    assign smask_o    = {4'b0000, size_mask(size_i)} << off_i;
    assign swdata_o   = {32'd0, wdata_i} << sh;
    assign misalign_o = |smask_o[7:4];
    assign ldata_o    = load_extend(32'(rdata_i >> sh), size_i, sgn_i);

endmodule

// File: rtl/vigna_lsu.sv
// vigna load/store unit: one request at a time, one or two word beats on the
// d_* bus, optional bus timeout, exactly one response pulse per accepted request.
module vigna_lsu import vigna_pkg::*; #(
    parameter bit          MISALIGN_SPLIT = 1'b1,
    parameter int unsigned TIMEOUT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    vigna_lsu_if.master dbus
);
    localparam int unsigned    TW       = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    logic [1:0]    state_q, state_d;
    lsu_req_t      req_q, req_d;
    logic [31:0]   lo_q, lo_d, hi_q, hi_d;
    logic          err_q, err_d;
    logic          dv_q, dv_d;
    logic [31:0]   da_q, da_d, dwd_q, dwd_d;
    logic [3:0]    ds_q, ds_d;
    logic [TW-1:0] cnt_q, cnt_d;

    logic          idle, tmo_hit, misalign;
    logic [7:0]    smask;
    logic [63:0]   swdata;
    logic [31:0]   ldata;

    assign idle = (state_q == ST_IDLE);

    // Single aligner: fed from the live request while idle, from the latched one after.
    vigna_lsu_align u_align (
        .off_i      (idle ? req_addr[1:0] : req_q.off),
        .size_i     (idle ? req_size      : req_q.size),
        .sgn_i      (req_q.sgn),
        .wdata_i    (idle ? req_wdata     : req_q.wdata),
        .rdata_i    ({hi_q, lo_q}),
        .smask_o    (smask),
        .swdata_o   (swdata),
        .misalign_o (misalign),
        .ldata_o    (ldata)
    );

    // Fires on the cycle the stall count would reach the limit; d_ready that cycle wins.
    assign tmo_hit = (TIMEOUT_CYCLES != 0) && dv_q && !dbus.d_ready && (cnt_q == TMO_LAST);

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        err_d   = err_q;
        dv_d    = dv_q;
        da_d    = da_q;
        dwd_d   = dwd_q;
        ds_d    = ds_q;
        cnt_d   = cnt_q;
        if ((TIMEOUT_CYCLES != 0) && dv_q && !dbus.d_ready) cnt_d = cnt_q + 1'b1;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    req_d = '{write: req_write, size: req_size, sgn: req_signed,
                              off: req_addr[1:0], wdata: req_wdata};
                    lo_d  = '0;
                    hi_d  = '0;
                    err_d = 1'b0;
                    cnt_d = '0;
                    if (!MISALIGN_SPLIT && misalign) begin
                        err_d   = 1'b1;
                        state_d = ST_RESP;
                    end else begin
                        dv_d    = 1'b1;
                        da_d    = {req_addr[31:2], 2'b00};
                        ds_d    = req_write ? smask[3:0] : 4'b0000;
                        dwd_d   = swdata[31:0];
                        state_d = ST_BEAT0;
                    end
                end
            end
            ST_BEAT0: begin
                if (dbus.d_ready) begin
                    lo_d  = dbus.d_rdata;
                    cnt_d = '0;
                    if (misalign) begin
                        da_d    = da_q + 32'd4;
                        ds_d    = req_q.write ? smask[7:4] : 4'b0000;
                        dwd_d   = swdata[63:32];
                        state_d = ST_BEAT1;
                    end else begin
                        dv_d    = 1'b0;
                        ds_d    = 4'b0000;
                        state_d = ST_RESP;
                    end
                end else if (tmo_hit) begin
                    dv_d    = 1'b0;
                    ds_d    = 4'b0000;
                    cnt_d   = '0;
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end
            end
            ST_BEAT1: begin
                if (dbus.d_ready) begin
                    hi_d    = dbus.d_rdata;
                    dv_d    = 1'b0;
                    ds_d    = 4'b0000;
                    cnt_d   = '0;
                    state_d = ST_RESP;
                end else if (tmo_hit) begin
                    // Beat 0 of a split store is already committed; only err reports it.
                    dv_d    = 1'b0;
                    ds_d    = 4'b0000;
                    cnt_d   = '0;
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            req_q   <= '0;
            lo_q    <= '0;
            hi_q    <= '0;
            err_q   <= 1'b0;
            dv_q    <= 1'b0;
            da_q    <= '0;
            dwd_q   <= '0;
            ds_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            err_q   <= err_d;
            dv_q    <= dv_d;
            da_q    <= da_d;
            dwd_q   <= dwd_d;
            ds_q    <= ds_d;
            cnt_q   <= cnt_d;
        end
    end

    assign req_ready    = idle;
    assign rsp_valid    = (state_q == ST_RESP);
    assign rsp_err      = rsp_valid && err_q;
    assign rsp_rdata    = (rsp_valid && !err_q && !req_q.write) ? ldata : 32'd0;

    assign dbus.d_valid = dv_q;
    assign dbus.d_addr  = da_q;
    assign dbus.d_wdata = dwd_q;
    assign dbus.d_wstrb = ds_q;

endmodule

// File: tb/tb_vigna_lsu.sv
// Directed bench for vigna_lsu: split/timeout instance (A) and reject instance (B);
// expected responses are queued at issue and checked by per-instance monitors.
module tb_vigna_lsu;
    import vigna_pkg::*;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    logic        req_write, req_signed;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        req_valid_a, req_ready_a, rsp_valid_a, rsp_err_a;
    logic        req_valid_b, req_ready_b, rsp_valid_b, rsp_err_b;
    logic [31:0] rsp_rdata_a, rsp_rdata_b;

    vigna_lsu_if bus_a ();
    vigna_lsu_if bus_b ();

    vigna_lsu #(.MISALIGN_SPLIT(1'b1), .TIMEOUT_CYCLES(8)) u_a (
        .clk(clk), .resetn(resetn),
        .req_valid(req_valid_a), .req_ready(req_ready_a), .req_write(req_write),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid_a), .rsp_rdata(rsp_rdata_a), .rsp_err(rsp_err_a),
        .dbus(bus_a.master)
    );

    vigna_lsu #(.MISALIGN_SPLIT(1'b0), .TIMEOUT_CYCLES(0)) u_b (
        .clk(clk), .resetn(resetn),
        .req_valid(req_valid_b), .req_ready(req_ready_b), .req_write(req_write),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid_b), .rsp_rdata(rsp_rdata_b), .rsp_err(rsp_err_b),
        .dbus(bus_b.master)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", nm, act, exp);
        end
    endtask

    task automatic push_a(input logic [31:0] rd, input logic err);
        exp_t e;
        e.rdata = rd;
        e.err   = err;
        qa.push_back(e);
    endtask

    task automatic push_b(input logic [31:0] rd, input logic err);
        exp_t e;
        e.rdata = rd;
        e.err   = err;
        qb.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rsp_valid_a === 1'b1) begin
            if (qa.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL rsp_a_unexpected: got rdata %h err %b, required no response",
                         rsp_rdata_a, rsp_err_a);
            end else begin
                e = qa.pop_front();
                chk("rsp_a_rdata", rsp_rdata_a, e.rdata);
                chk("rsp_a_err", {31'd0, rsp_err_a}, {31'd0, e.err});
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rsp_valid_b === 1'b1) begin
            if (qb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL rsp_b_unexpected: got rdata %h err %b, required no response",
                         rsp_rdata_b, rsp_err_b);
            end else begin
                e = qb.pop_front();
                chk("rsp_b_rdata", rsp_rdata_b, e.rdata);
                chk("rsp_b_err", {31'd0, rsp_err_b}, {31'd0, e.err});
            end
        end
    end

    task automatic issue(input bit sel, input logic w, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd);
        @(posedge clk);
        #1;
        req_write  = w;
        req_size   = sz;
        req_signed = sg;
        req_addr   = a;
        req_wdata  = wd;
        if (sel) req_valid_b = 1'b1;
        else     req_valid_a = 1'b1;
        @(posedge clk);
        #1;
        req_valid_a = 1'b0;
        req_valid_b = 1'b0;
    endtask

    // One beat on bus A: stall for 'waits' cycles, then check and complete it.
    task automatic beat(input logic [31:0] addr, input logic [3:0] strb, input logic [31:0] wd,
                        input logic [31:0] rd, input int waits);
        for (int i = 0; i < waits; i++) begin
            @(negedge clk);
            chk("stall_dvalid", {31'd0, bus_a.d_valid}, 32'd1);
            chk("stall_daddr", bus_a.d_addr, addr);
        end
        @(negedge clk);
        chk("beat_dvalid", {31'd0, bus_a.d_valid}, 32'd1);
        chk("beat_daddr", bus_a.d_addr, addr);
        chk("beat_dwstrb", {28'd0, bus_a.d_wstrb}, {28'd0, strb});
        chk("beat_dwdata", bus_a.d_wdata, wd);
        chk("busy_req_ready", {31'd0, req_ready_a}, 32'd0);
        bus_a.d_ready = 1'b1;
        bus_a.d_rdata = rd;
        @(posedge clk);
        #1;
        bus_a.d_ready = 1'b0;
        bus_a.d_rdata = 32'd0;
    endtask

    task automatic expect_rsp_a();
        @(negedge clk);
        chk("rsp_a_pulse", {31'd0, rsp_valid_a}, 32'd1);
        chk("rsp_a_dvalid_low", {31'd0, bus_a.d_valid}, 32'd0);
        chk("rsp_a_dwstrb_low", {28'd0, bus_a.d_wstrb}, 32'd0);
        @(negedge clk);
        chk("rsp_a_one_cycle", {31'd0, rsp_valid_a}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn        = 1'b0;
        req_valid_a   = 1'b0;
        req_valid_b   = 1'b0;
        req_write     = 1'b0;
        req_size      = SZ_W;
        req_signed    = 1'b0;
        req_addr      = 32'd0;
        req_wdata     = 32'd0;
        bus_a.d_ready = 1'b0;
        bus_a.d_rdata = 32'd0;
        bus_b.d_ready = 1'b0;
        bus_b.d_rdata = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_dvalid", {31'd0, bus_a.d_valid}, 32'd0);
        chk("rst_daddr", bus_a.d_addr, 32'd0);
        chk("rst_dwdata", bus_a.d_wdata, 32'd0);
        chk("rst_dwstrb", {28'd0, bus_a.d_wstrb}, 32'd0);
        chk("rst_rsp", {30'd0, rsp_valid_a, rsp_err_a}, 32'd0);
        chk("rst_rdata", rsp_rdata_a, 32'd0);
        chk("rst_req_ready", {31'd0, req_ready_a}, 32'd1);
        @(posedge clk);
        #1;
        resetn = 1'b1;

        // lb / lbu at 0x1003
        push_a(32'hFFFF_FF80, 1'b0);
        issue(1'b0, 1'b0, SZ_B, 1'b1, 32'h0000_1003, 32'd0);
        beat(32'h0000_1000, 4'b0000, 32'd0, 32'h80FF_1234, 0);
        expect_rsp_a();
        push_a(32'h0000_0080, 1'b0);
        issue(1'b0, 1'b0, SZ_B, 1'b0, 32'h0000_1003, 32'd0);
        beat(32'h0000_1000, 4'b0000, 32'd0, 32'h80FF_1234, 0);
        expect_rsp_a();

        // Store lanes
        push_a(32'd0, 1'b0);
        issue(1'b0, 1'b1, SZ_H, 1'b0, 32'h0000_2002, 32'h0000_ABCD);
        beat(32'h0000_2000, 4'b1100, 32'hABCD_0000, 32'hFFFF_FFFF, 0);
        expect_rsp_a();
        push_a(32'd0, 1'b0);
        issue(1'b0, 1'b1, SZ_B, 1'b0, 32'h0000_2001, 32'h0000_005A);
        beat(32'h0000_2000, 4'b0010, 32'h0000_5A00, 32'd0, 0);
        expect_rsp_a();

        // Signed half with wait states
        push_a(32'hFFFF_8001, 1'b0);
        issue(1'b0, 1'b0, SZ_H, 1'b1, 32'h0000_1002, 32'd0);
        beat(32'h0000_1000, 4'b0000, 32'd0, 32'h8001_1234, 3);
        expect_rsp_a();

        // Split load and split store
        push_a(32'h5544_3322, 1'b0);
        issue(1'b0, 1'b0, SZ_W, 1'b0, 32'h0000_3001, 32'd0);
        beat(32'h0000_3000, 4'b0000, 32'd0, 32'h4433_2211, 0);
        beat(32'h0000_3004, 4'b0000, 32'd0, 32'h8877_6655, 0);
        expect_rsp_a();
        push_a(32'd0, 1'b0);
        issue(1'b0, 1'b1, SZ_W, 1'b0, 32'h0000_3003, 32'hDEAD_BEEF);
        beat(32'h0000_3000, 4'b1000, 32'hEF00_0000, 32'd0, 0);
        beat(32'h0000_3004, 4'b0111, 32'h00DE_ADBE, 32'd0, 0);
        expect_rsp_a();

        // Timeout with d_ready held low
        push_a(32'd0, 1'b1);
        issue(1'b0, 1'b0, SZ_W, 1'b0, 32'h0000_5000, 32'd0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("tmo_dvalid_high", {31'd0, bus_a.d_valid}, 32'd1);
        end
        @(negedge clk);
        chk("tmo_dvalid_drop", {31'd0, bus_a.d_valid}, 32'd0);
        chk("tmo_rsp_valid", {31'd0, rsp_valid_a}, 32'd1);
        @(negedge clk);
        chk("tmo_rsp_one_cycle", {31'd0, rsp_valid_a}, 32'd0);

        // d_ready in the limit cycle wins over the timeout
        push_a(32'h1234_5678, 1'b0);
        issue(1'b0, 1'b0, SZ_W, 1'b0, 32'h0000_5000, 32'd0);
        beat(32'h0000_5000, 4'b0000, 32'd0, 32'h1234_5678, 7);
        expect_rsp_a();

        // Reset mid-BEAT0: no response, outputs cleared
        issue(1'b0, 1'b1, SZ_W, 1'b0, 32'h0000_6000, 32'hCAFE_F00D);
        @(negedge clk);
        chk("abort_dvalid_pre", {31'd0, bus_a.d_valid}, 32'd1);
        resetn = 1'b0;
        @(negedge clk);
        chk("abort_dvalid", {31'd0, bus_a.d_valid}, 32'd0);
        chk("abort_daddr", bus_a.d_addr, 32'd0);
        chk("abort_dwdata", bus_a.d_wdata, 32'd0);
        chk("abort_dwstrb", {28'd0, bus_a.d_wstrb}, 32'd0);
        chk("abort_rsp", {31'd0, rsp_valid_a}, 32'd0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        push_a(32'd0, 1'b0);
        issue(1'b0, 1'b1, SZ_B, 1'b0, 32'h0000_6003, 32'h0000_0077);
        beat(32'h0000_6000, 4'b1000, 32'h7700_0000, 32'd0, 0);
        expect_rsp_a();

        // Reject instance: misaligned lh and sw, no bus traffic
        push_b(32'd0, 1'b1);
        issue(1'b1, 1'b0, SZ_H, 1'b1, 32'h0000_4003, 32'd0);
        @(negedge clk);
        chk("rej_lh_rsp", {31'd0, rsp_valid_b}, 32'd1);
        chk("rej_lh_dvalid", {31'd0, bus_b.d_valid}, 32'd0);
        @(negedge clk);
        chk("rej_lh_one_cycle", {31'd0, rsp_valid_b}, 32'd0);
        push_b(32'd0, 1'b1);
        issue(1'b1, 1'b1, SZ_W, 1'b0, 32'h0000_4001, 32'h1122_3344);
        @(negedge clk);
        chk("rej_sw_rsp", {31'd0, rsp_valid_b}, 32'd1);
        chk("rej_sw_dvalid", {31'd0, bus_b.d_valid}, 32'd0);
        chk("rej_sw_dwstrb", {28'd0, bus_b.d_wstrb}, 32'd0);

        repeat (3) @(negedge clk);
        chk("qa_drained", 32'(qa.size()), 32'd0);
        chk("qb_drained", 32'(qb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
